// File: rtl/sdp_mem_pkg.sv
// sdp_mem_pkg
// Shared definitions for the handshaked simple-dual-port memory:
//   LAT_MIN / LAT_MAX : bounds of the read latency (1 + OUT_REG)
//   rdw_mode_e        : same-edge same-address read/write behaviour
//   be_merge()        : per-byte select between old and new data
package sdp_mem_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  typedef enum logic {
    RDW_OLD = 1'b0,  // read sees the word as it was before the write
    RDW_NEW = 1'b1   // read sees the word with the write merged in
  } rdw_mode_e;

  // One byte lane of a byte-enabled merge: take the new byte when enabled.
  function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sdp_mem_hs_if.sv
// sdp_mem_hs_if
// Bundles the write port, read-request port, read-response port and the
// sticky out-of-range flag of sdp_mem_hs.
//   master : the client (drives requests, consumes responses)
//   slave  : the memory
interface sdp_mem_hs_if #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 6
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [W_ADDR-1:0]     wr_addr;
  logic [W_DATA-1:0]     wr_data;
  logic [W_DATA/8-1:0]   wr_be;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [W_ADDR-1:0]     rd_req_addr;

  logic                  rd_resp_valid;
  logic                  rd_resp_ready;
  logic [W_DATA-1:0]     rd_resp_data;

  logic                  err_oob;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be,
    output rd_req_valid, rd_req_addr,
    output rd_resp_ready,
    input  wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data, err_oob
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be,
    input  rd_req_valid, rd_req_addr,
    input  rd_resp_ready,
    output wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data, err_oob
  );

endinterface

// File: rtl/sdp_resp_buf.sv
// sdp_resp_buf
// Small FIFO holding read responses until the consumer takes them.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push       : write push_data at the tail
//   pop        : drop the head (ignored when empty)
//   head       : oldest entry, forced to zero while empty
//   valid      : FIFO non-empty
//   count      : number of stored entries
module sdp_resp_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop && (count_reg != '0);
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign push_ok = push && ((count_reg != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign valid = (count_reg != '0);
  assign head  = valid ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/sdp_mem_hs.sv
// sdp_mem_hs
// Simple-dual-port memory with valid/ready handshakes on write, read request
// and read response, byte-enable writes, read latency 1 + OUT_REG, selectable
// read-during-write behaviour and a LAT+1 deep response buffer.
//   clk, rst_n : clock, asynchronous active-low reset (array is not reset)
//   bus        : sdp_mem_hs_if.slave (wr_*, rd_req_*, rd_resp_*, err_oob)
module sdp_mem_hs
  import sdp_mem_pkg::*;
#(
  parameter int W_DATA   = 16,
  parameter int W_ADDR   = 6,
  parameter int DEPTH    = 64,
  parameter int OUT_REG  = 1,
  parameter int RDW_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  sdp_mem_hs_if.slave bus
);

  localparam int LAT       = LAT_MIN + OUT_REG;
  localparam int NB        = W_DATA / 8;
  localparam int BUF_DEPTH = LAT + 1;
  localparam int NW        = $clog2(BUF_DEPTH + 1);
  localparam bit FWD_NEW   = (RDW_MODE == int'(RDW_NEW));
  localparam logic [W_ADDR:0] DEPTH_W = (W_ADDR + 1)'(DEPTH);

  logic              wr_ready_reg;
  logic              err_oob_reg;
  logic              wr_fire, wr_in_range;
  logic              rd_fire, rd_in_range;
  logic              resp_fire, resp_valid;
  logic              rd_req_ready;
  logic [NW-1:0]     outst;
  logic [NW-1:0]     buf_count;
  logic [W_DATA-1:0] buf_head;

  logic [W_DATA-1:0] ram [DEPTH];
  logic [W_DATA-1:0] ram_q_reg;
  logic              s1_valid_reg, s1_oob_reg, s1_fwd_reg;
  logic [W_DATA-1:0] s1_wdata_reg;
  logic [NB-1:0]     s1_wbe_reg;
  logic [W_DATA-1:0] s1_data;
  logic              pipe_valid;   // last pipeline stage feeding the buffer
  logic [W_DATA-1:0] pipe_data;
  logic              s2_busy;      // extra stage occupied (0 when OUT_REG=0)

  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, bus.rd_req_addr} < DEPTH_W);
  assign wr_fire     = bus.wr_valid && wr_ready_reg;
  assign resp_fire   = resp_valid && bus.rd_resp_ready;
  assign rd_fire     = bus.rd_req_valid && rd_req_ready;

  // Outstanding = everything in the read pipeline plus everything buffered.
  // The buffer has LAT+1 slots, so capping this at LAT+1 means a response can
  // never find the buffer full; a pop in the same cycle frees one slot.
  assign outst = buf_count + NW'(s1_valid_reg) + NW'(s2_busy);
  assign rd_req_ready = wr_ready_reg && ((outst < NW'(LAT + 1)) || resp_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ready_reg <= 1'b0;
    else        wr_ready_reg <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_oob_reg <= 1'b0;
    end else if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) begin
      err_oob_reg <= 1'b1;
    end
  end

  // Array: byte-enabled write and registered read, kept free of reset so it
  // maps onto block RAM. Reading the old word on a same-address collision is
  // the natural behaviour of this template.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) ram[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire) ram_q_reg <= ram[bus.rd_req_addr];
  end

  // Side information travelling with the RAM read: out-of-range marker and,
  // for new-data mode, the colliding write so it can be merged after the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_oob_reg   <= 1'b0;
      s1_fwd_reg   <= 1'b0;
      s1_wdata_reg <= '0;
      s1_wbe_reg   <= '0;
    end else begin
      s1_valid_reg <= rd_fire;
      if (rd_fire) begin
        s1_oob_reg   <= !rd_in_range;
        s1_fwd_reg   <= FWD_NEW && wr_fire && wr_in_range &&
                        (bus.wr_addr == bus.rd_req_addr);
        s1_wdata_reg <= bus.wr_data;
        s1_wbe_reg   <= bus.wr_be;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign s1_data[8*gi +: 8] = s1_oob_reg ? 8'h00 :
          be_merge(ram_q_reg[8*gi +: 8], s1_wdata_reg[8*gi +: 8],
                   s1_fwd_reg && s1_wbe_reg[gi]);
    end

    if (OUT_REG != 0) begin : g_out_reg
      logic              s2_valid_reg;
      logic [W_DATA-1:0] s2_data_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_reg <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) s2_data_reg <= s1_data;
        end
      end
      assign pipe_valid = s2_valid_reg;
      assign pipe_data  = s2_data_reg;
      assign s2_busy    = s2_valid_reg;
    end else begin : g_no_out_reg
      assign pipe_valid = s1_valid_reg;
      assign pipe_data  = s1_data;
      assign s2_busy    = 1'b0;
    end
  endgenerate

  sdp_resp_buf #(
    .W     (W_DATA),
    .DEPTH (BUF_DEPTH),
    .CW    (NW)
  ) u_resp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_valid),
    .push_data (pipe_data),
    .pop       (resp_fire),
    .head      (buf_head),
    .valid     (resp_valid),
    .count     (buf_count)
  );

  assign bus.wr_ready      = wr_ready_reg;
  assign bus.rd_req_ready  = rd_req_ready;
  assign bus.rd_resp_valid = resp_valid;
  assign bus.rd_resp_data  = buf_head;
  assign bus.err_oob       = err_oob_reg;

endmodule

// File: tb/tb_sdp_mem_hs.sv
// tb_sdp_mem_hs
// Scoreboarded bench for sdp_mem_hs: the driver computes each read's expected
// word from a plain array model at accept time and queues it; an independent
// monitor pops and compares on every response handshake.
module tb_sdp_mem_hs;

  localparam int W_DATA   = 16;
  localparam int W_ADDR   = 6;
  localparam int DEPTH    = 48;
  localparam int OUT_REG  = 1;
  localparam int RDW_MODE = 1;
  localparam int LAT      = 1 + OUT_REG;
  localparam int NB       = W_DATA / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdp_mem_hs_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) bus ();

  sdp_mem_hs #(
    .W_DATA   (W_DATA),
    .W_ADDR   (W_ADDR),
    .DEPTH    (DEPTH),
    .OUT_REG  (OUT_REG),
    .RDW_MODE (RDW_MODE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int resp_mode = 0;           // 0: hold off, 1: always ready, 2: random
  logic [W_DATA-1:0] model [DEPTH];
  logic [W_DATA-1:0] exp_q [$];
  int resp_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic logic [W_DATA-1:0] apply_be(input logic [W_DATA-1:0] old_w,
                                                 input logic [W_DATA-1:0] new_w,
                                                 input logic [NB-1:0] be);
    logic [W_DATA-1:0] r = old_w;
    for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input bit wv, input int wa, input logic [W_DATA-1:0] wd,
                       input logic [NB-1:0] wbe, input bit rv, input int ra,
                       output bit rfire);
    bit wfire;
    logic [W_DATA-1:0] e;
    bus.wr_valid     = wv;
    bus.wr_addr      = W_ADDR'(wa);
    bus.wr_data      = wd;
    bus.wr_be        = wbe;
    bus.rd_req_valid = rv;
    bus.rd_req_addr  = W_ADDR'(ra);
    @(negedge clk);
    wfire = wv && bus.wr_ready;
    rfire = rv && bus.rd_req_ready;
    if (rfire) begin
      e = (ra < DEPTH) ? model[ra] : '0;
      if (RDW_MODE == 1 && wfire && wa == ra && ra < DEPTH) e = apply_be(e, wd, wbe);
      exp_q.push_back(e);
      $display("req  rd addr=%0d expect=%h cycle=%0d", ra, e, cyc);
    end
    if (wfire && wa < DEPTH) model[wa] = apply_be(model[wa], wd, wbe);
    @(posedge clk); #1;
    bus.wr_valid     = 1'b0;
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) idle(1);
    chk(name, exp_q.size(), 0);
  endtask

  // Consumer ready generator, updated after the driver settles its inputs.
  initial begin
    bus.rd_resp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.rd_resp_ready = (resp_mode == 2) ? 1'($urandom_range(0, 1)) : (resp_mode == 1);
    end
  end

  // Monitor: compare on every response handshake, check stability under stall.
  initial begin
    logic held;
    logic [W_DATA-1:0] held_data;
    logic [W_DATA-1:0] e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", bus.rd_resp_valid, 1);
          chk("hold_data", bus.rd_resp_data, held_data);
        end
        held = 1'b0;
        if (bus.rd_resp_valid && bus.rd_resp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL resp_unexpected: got %h expected no response (cycle %0d)",
                     bus.rd_resp_data, cyc);
          end else begin
            e = exp_q.pop_front();
            $display("resp data=%h expect=%h cycle=%0d", bus.rd_resp_data, e, cyc);
            chk("resp_data", bus.rd_resp_data, e);
            resp_cyc.push_back(cyc);
          end
        end else if (bus.rd_resp_valid) begin
          held = 1'b1;
          held_data = bus.rd_resp_data;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int acc, gaps, stale, wa, ra;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_req_valid = 0; bus.rd_req_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", bus.rd_resp_valid, 0);
    chk("rst_resp_data", bus.rd_resp_data, 0);
    chk("rst_err_oob", bus.err_oob, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wr_ready_up", bus.wr_ready, 1);
    chk("rd_req_ready_up", bus.rd_req_ready, 1);

    for (int i = 0; i < DEPTH; i++) drive(1, i, W_DATA'($urandom), '1, 0, 0, f);
    resp_mode = 1;

    // 1: basic write/read and latency
    drive(1, 5, 16'hA5C3, 2'b11, 0, 0, f);
    drive(0, 0, '0, '0, 1, 5, f);
    chk("t1_accept", f, 1);
    @(negedge clk); chk("t1_lat_e0", bus.rd_resp_valid, 0);
    @(negedge clk); chk("t1_lat_e1", bus.rd_resp_valid, 0);
    @(negedge clk); chk("t1_lat_e2", bus.rd_resp_valid, 1);
    chk("t1_data", bus.rd_resp_data, 16'hA5C3);
    chk("t1_err_oob", bus.err_oob, 0);
    @(posedge clk); #1;

    // 2: byte enables
    drive(1, 7, 16'h1234, 2'b11, 0, 0, f);
    drive(1, 7, 16'hABCD, 2'b01, 0, 0, f);
    drive(0, 0, '0, '0, 1, 7, f);

    // 3: same-edge read and write
    drive(1, 3, 16'h0001, 2'b11, 0, 0, f);
    drive(1, 3, 16'hFFFF, 2'b11, 1, 3, f);
    wait_drain("t123_drain", 20);

    // 4: backpressure and full throughput
    resp_mode = 0;
    resp_cyc.delete();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, '0, '0, 1, acc, f);
      if (f) acc++;
    end
    chk("t4_accepted", acc, 3);
    chk("t4_req_ready_low", bus.rd_req_ready, 0);
    resp_mode = 1;
    for (int k = 0; k < 40 && acc < 10; k++) begin
      drive(0, 0, '0, '0, 1, acc, f);
      if (f) acc++;
    end
    chk("t4_all_accepted", acc, 10);
    wait_drain("t4_drain", 20);
    chk("t4_resp_count", resp_cyc.size(), 10);
    gaps = 0;
    for (int i = 1; i < resp_cyc.size(); i++) if (resp_cyc[i] - resp_cyc[i-1] != 1) gaps++;
    chk("t4_gaps", gaps, 0);

    // 5: out of range
    chk("t5_err_before", bus.err_oob, 0);
    drive(1, 50, 16'hDEAD, 2'b11, 0, 0, f);
    chk("t5_err_after", bus.err_oob, 1);
    drive(0, 0, '0, '0, 1, 50, f);
    drive(0, 0, '0, '0, 1, 2, f);
    drive(0, 0, '0, '0, 1, 18, f);
    wait_drain("t5_drain", 20);

    // 6: reset with reads in flight
    resp_mode = 0;
    drive(0, 0, '0, '0, 1, 1, f);
    drive(0, 0, '0, '0, 1, 2, f);
    @(posedge clk); #2;
    chk("t6_valid_before", bus.rd_resp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", bus.rd_resp_valid, 0);
    chk("t6_data_async", bus.rd_resp_data, 0);
    chk("t6_wr_ready_rst", bus.wr_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    resp_mode = 1;
    @(posedge clk); #1;
    chk("t6_wr_ready", bus.wr_ready, 1);
    chk("t6_rd_req_ready", bus.rd_req_ready, 1);
    chk("t6_err_cleared", bus.err_oob, 0);
    stale = 0;
    repeat (6) begin @(negedge clk); if (bus.rd_resp_valid) stale++; end
    chk("t6_no_stale", stale, 0);
    @(posedge clk); #1;

    // Random traffic; memory contents must have survived the reset
    resp_mode = 2;
    for (int k = 0; k < 400; k++) begin
      wa = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 63) : $urandom_range(0, 7);
      ra = ($urandom_range(0, 2) == 0) ? wa :
           (($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 63) : $urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), wa, W_DATA'($urandom), NB'($urandom),
            1'($urandom_range(0, 1)), ra, f);
    end
    resp_mode = 1;
    wait_drain("final_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
